// File: rtl/exec_pkg.sv
// Shared types and constants for the execution sequencer: FSM states,
// 7-bit decode keys {funct3, opcode[3:0]} and the 4-bit ALU operation codes.
package exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] KEY_ADD  = 7'b000_0001;
    localparam logic [6:0] KEY_SUB  = 7'b001_0001;
    localparam logic [6:0] KEY_SLL  = 7'b000_0011;
    localparam logic [6:0] KEY_SRL  = 7'b001_0011;
    localparam logic [6:0] KEY_SRA  = 7'b010_0011;
    localparam logic [6:0] KEY_SLT  = 7'b000_0111;
    localparam logic [6:0] KEY_SLTU = 7'b001_0111;
    localparam logic [6:0] KEY_XOR  = 7'b000_1111;
    localparam logic [6:0] KEY_OR   = 7'b001_1111;
    localparam logic [6:0] KEY_AND  = 7'b010_1111;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SLL  = 4'h3;
    localparam logic [3:0] OP_SRL  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_AND  = 4'hA;

endpackage

// File: rtl/exec_sequencer_op_decode.sv
// Combinational decode of the 7-bit instruction key into an ALU operation;
// any key outside the table falls back to ADD.
module op_decode
    import exec_pkg::*;
(
    input  logic [6:0] key_i,
    output logic [3:0] alu_op_o
);

    // Key lookup table with ADD as the fallback
    always_comb begin
        alu_op_o = OP_ADD;
        case (key_i)
            KEY_ADD:  alu_op_o = OP_ADD;
            KEY_SUB:  alu_op_o = OP_SUB;
            KEY_SLL:  alu_op_o = OP_SLL;
            KEY_SRL:  alu_op_o = OP_SRL;
            KEY_SRA:  alu_op_o = OP_SRA;
            KEY_SLT:  alu_op_o = OP_SLT;
            KEY_SLTU: alu_op_o = OP_SLTU;
            KEY_XOR:  alu_op_o = OP_XOR;
            KEY_OR:   alu_op_o = OP_OR;
            KEY_AND:  alu_op_o = OP_AND;
            default:  alu_op_o = OP_ADD;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB with a sticky fetch-timeout TRAP.
// Optional retired-instruction counter enabled by defining EXEC_SEQ_PERF_CNT_EN.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned FETCH_TMO = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        alu_en,
    output logic [3:0]  alu_op,
    input  logic        alu_done,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    output logic [4:0]  rf_waddr,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        busy,
`ifdef EXEC_SEQ_PERF_CNT_EN
    output logic [31:0] retired,
`endif
    output logic        trap
);

    localparam logic [7:0] TMO_LAST = 8'(FETCH_TMO - 1);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [7:0]  tmo_cnt_q;
    logic [6:0]  ir_key_q;
    logic [4:0]  ir_rd_q;
    logic [4:0]  ir_rs1_q;
    logic [4:0]  ir_rs2_q;
    logic        imem_req_q;
    logic        alu_en_q;
    logic [3:0]  alu_op_q;
    logic [4:0]  rf_raddr1_q;
    logic [4:0]  rf_raddr2_q;
    logic [4:0]  rf_waddr_q;
    logic        rf_we_q;
    logic        trap_q;
    logic [3:0]  dec_op_s;
    logic        unused_rdata_s;
`ifdef EXEC_SEQ_PERF_CNT_EN
    logic [31:0] retired_q;
`endif

    assign pc_d           = pc_q + 32'd4;
    assign unused_rdata_s = ^{imem_rdata[31:25], imem_rdata[6:4]};

    op_decode u_op_decode (
        .key_i    (ir_key_q),
        .alu_op_o (dec_op_s)
    );

    // Sequencer FSM with all outputs registered; the fetch counter and pc live here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_RESET;
            tmo_cnt_q   <= 8'd0;
            ir_key_q    <= 7'd0;
            ir_rd_q     <= 5'd0;
            ir_rs1_q    <= 5'd0;
            ir_rs2_q    <= 5'd0;
            imem_req_q  <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_op_q    <= 4'h0;
            rf_raddr1_q <= 5'd0;
            rf_raddr2_q <= 5'd0;
            rf_waddr_q  <= 5'd0;
            rf_we_q     <= 1'b0;
            trap_q      <= 1'b0;
`ifdef EXEC_SEQ_PERF_CNT_EN
            retired_q   <= 32'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run && !trap_q) begin
                        state_q    <= ST_FETCH;
                        imem_req_q <= 1'b1;
                        tmo_cnt_q  <= 8'd0;
                    end
                end
                ST_FETCH: begin
                    // An ack in the expiry cycle still completes the fetch
                    if (imem_ack) begin
                        ir_key_q   <= {imem_rdata[14:12], imem_rdata[3:0]};
                        ir_rd_q    <= imem_rdata[11:7];
                        ir_rs1_q   <= imem_rdata[19:15];
                        ir_rs2_q   <= imem_rdata[24:20];
                        imem_req_q <= 1'b0;
                        state_q    <= ST_DECODE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        imem_req_q <= 1'b0;
                        trap_q     <= 1'b1;
                        state_q    <= ST_TRAP;
                    end else begin
                        tmo_cnt_q  <= tmo_cnt_q + 8'd1;
                    end
                end
                ST_DECODE: begin
                    rf_raddr1_q <= ir_rs1_q;
                    rf_raddr2_q <= ir_rs2_q;
                    rf_waddr_q  <= ir_rd_q;
                    alu_op_q    <= dec_op_s;
                    alu_en_q    <= 1'b1;
                    state_q     <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (alu_done) begin
                        alu_en_q <= 1'b0;
                        rf_we_q  <= (rf_waddr_q != 5'd0);
                        state_q  <= ST_WB;
                    end
                end
                ST_WB: begin
                    rf_we_q <= 1'b0;
                    pc_q    <= pc_d;
`ifdef EXEC_SEQ_PERF_CNT_EN
                    retired_q <= retired_q + 32'd1;
`endif
                    if (run) begin
                        state_q    <= ST_FETCH;
                        imem_req_q <= 1'b1;
                        tmo_cnt_q  <= 8'd0;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_TRAP: begin
                    trap_q     <= 1'b1;
                    imem_req_q <= 1'b0;
                    alu_en_q   <= 1'b0;
                    rf_we_q    <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    imem_req_q <= 1'b0;
                    alu_en_q   <= 1'b0;
                    rf_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign alu_en    = alu_en_q;
    assign alu_op    = alu_op_q;
    assign rf_raddr1 = rf_raddr1_q;
    assign rf_raddr2 = rf_raddr2_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_we     = rf_we_q;
    assign pc        = pc_q;
    assign busy      = (state_q != ST_IDLE);
    assign trap      = trap_q;
`ifdef EXEC_SEQ_PERF_CNT_EN
    assign retired   = retired_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a scoreboard of expected writeback results.
module tb_exec_sequencer;

    localparam logic [31:0] PC_RST = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic        alu_done;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic [31:0] pc;
    logic        busy;
    logic        trap;
`ifdef EXEC_SEQ_PERF_CNT_EN
    logic [31:0] retired;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] pc_next;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    always #5 clk = ~clk;

    exec_sequencer #(
        .PC_RESET  (PC_RST),
        .FETCH_TMO (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .alu_done   (alu_done),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .pc         (pc),
        .busy       (busy),
`ifdef EXEC_SEQ_PERF_CNT_EN
        .retired    (retired),
`endif
        .trap       (trap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_op(input logic [31:0] inst);
        case ({inst[14:12], inst[3:0]})
            7'b000_0001: return 4'h1;
            7'b001_0001: return 4'h2;
            7'b000_0011: return 4'h3;
            7'b001_0011: return 4'h4;
            7'b010_0011: return 4'h5;
            7'b000_0111: return 4'h6;
            7'b001_0111: return 4'h7;
            7'b000_1111: return 4'h8;
            7'b001_1111: return 4'h9;
            7'b010_1111: return 4'hA;
            default:     return 4'h1;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [3:0] low4,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'b101_0101, rs2, rs1, f3, rd, 3'b101, low4};
    endfunction

    task automatic start();
        run = 1'b1;
        @(negedge clk);
        chk("start_busy", busy, 32'd1);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves one cycle after WB
    task automatic run_instr(input logic [31:0] inst, input int ack_dly,
                             input int done_dly, input logic run_after);
        exp_t e;
        for (int i = 0; i < ack_dly; i++) begin
            chk("fetch_wait_req", imem_req, 32'd1);
            chk("fetch_wait_trap", trap, 32'd0);
            @(negedge clk);
        end
        chk("fetch_req", imem_req, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = inst;
        e.op      = model_op(inst);
        e.waddr   = inst[11:7];
        e.we      = (inst[11:7] != 5'd0);
        e.pc_next = exp_pc + 32'd4;
        sb_q.push_back(e);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("decode_req_drop", imem_req, 32'd0);
        chk("decode_alu_en", alu_en, 32'd0);
        @(negedge clk);
        run = run_after;
        chk("exec_alu_en", alu_en, 32'd1);
        chk("exec_alu_op", alu_op, sb_q[0].op);
        chk("exec_raddr1", rf_raddr1, inst[19:15]);
        chk("exec_raddr2", rf_raddr2, inst[24:20]);
        chk("exec_waddr", rf_waddr, inst[11:7]);
        for (int i = 0; i < done_dly; i++) begin
            @(negedge clk);
            chk("exec_hold_en", alu_en, 32'd1);
            chk("exec_hold_op", alu_op, sb_q[0].op);
            chk("exec_hold_we", rf_we, 32'd0);
        end
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        e = sb_q.pop_front();
        chk("wb_we", rf_we, e.we);
        chk("wb_waddr", rf_waddr, e.waddr);
        chk("wb_op", alu_op, e.op);
        chk("wb_alu_en", alu_en, 32'd0);
        chk("wb_pc_hold", pc, exp_pc);
        exp_pc  = e.pc_next;
        exp_ret = exp_ret + 32'd1;
        @(negedge clk);
        chk("post_wb_pc", pc, exp_pc);
        chk("post_wb_we", rf_we, 32'd0);
        chk("post_wb_busy", busy, run_after);
        chk("post_wb_req", imem_req, run_after);
`ifdef EXEC_SEQ_PERF_CNT_EN
        chk("retired", retired, exp_ret);
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        alu_done   = 1'b0;
        exp_pc     = PC_RST;
        exp_ret    = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, PC_RST);
        chk("rst_trap", trap, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_req", imem_req, 32'd0);
        chk("rst_alu_en", alu_en, 32'd0);
        chk("rst_alu_op", alu_op, 32'd0);
        chk("rst_we", rf_we, 32'd0);
        chk("rst_raddr1", rf_raddr1, 32'd0);
`ifdef EXEC_SEQ_PERF_CNT_EN
        chk("rst_retired", retired, 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_run", busy, 32'd0);

        // Back-to-back instructions, first one wraps pc to 0
        start();
        run_instr(32'h0020_80B3, 0, 0, 1'b1);
        run_instr(mk(3'b001, 4'b0001, 5'd0, 5'd5, 5'd6), 2, 0, 1'b1);
        run_instr(mk(3'b111, 4'b0000, 5'd7, 5'd9, 5'd10), 1, 1, 1'b1);
        run_instr(mk(3'b000, 4'b1111, 5'd31, 5'd31, 5'd0), 0, 2, 1'b1);
        run_instr(mk(3'b010, 4'b0011, 5'd12, 5'd3, 5'd4), 0, 0, 1'b1);
        run_instr(mk(3'b001, 4'b0111, 5'd2, 5'd17, 5'd18), 0, 0, 1'b1);
        run_instr(mk(3'b010, 4'b1111, 5'd8, 5'd1, 5'd30), 0, 0, 1'b1);
        // run dropped during a long EXEC: instruction completes, then IDLE
        run_instr(mk(3'b001, 4'b1111, 5'd9, 5'd14, 5'd15), 0, 5, 1'b0);
        repeat (2) @(negedge clk);
        chk("idle_after_stop", busy, 32'd0);

        // Asynchronous reset in the middle of EXEC
        start();
        imem_ack   = 1'b1;
        imem_rdata = mk(3'b000, 4'b0001, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        imem_ack   = 1'b0;
        @(negedge clk);
        chk("pre_rst_alu_en", alu_en, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_alu_en", alu_en, 32'd0);
        chk("async_busy", busy, 32'd0);
        chk("async_pc", pc, PC_RST);
        chk("async_alu_op", alu_op, 32'd0);
        exp_pc  = PC_RST;
        exp_ret = 32'd0;
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pc", pc, PC_RST);
        chk("post_rst_we", rf_we, 32'd0);
`ifdef EXEC_SEQ_PERF_CNT_EN
        chk("post_rst_retired", retired, 32'd0);
`endif

        // Fetch timeout: three unanswered FETCH cycles, then sticky TRAP
        start();
        for (int i = 0; i < 3; i++) begin
            chk("tmo_wait_req", imem_req, 32'd1);
            chk("tmo_wait_trap", trap, 32'd0);
            @(negedge clk);
        end
        chk("trap_set", trap, 32'd1);
        chk("trap_req", imem_req, 32'd0);
        chk("trap_alu_en", alu_en, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("trap_sticky", trap, 32'd1);
            chk("trap_busy", busy, 32'd1);
            chk("trap_req_hold", imem_req, 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("trap_cleared", trap, 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("trap_rst_busy", busy, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
